// File: rtl/sysreg_pkg.sv
// Shared encodings for the SPR stack-access controller: FSM states and
// memory read/write direction.
package sysreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } stackState_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/sysreg_spr_stack_ctrl_if.sv
// Load/store memory port used by the SPR stack controller; the controller is
// the master, the memory system is the slave.
interface sysreg_spr_stack_ctrl_if #(
  parameter int N = 32
);

  logic         oMEM_REQ;
  logic         oMEM_RW;
  logic [N-1:0] oMEM_ADDR;
  logic [N-1:0] oMEM_DATA;
  logic         iMEM_BUSY;
  logic         iMEM_VALID;
  logic [N-1:0] iMEM_DATA;

  modport master (
    output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    input  iMEM_BUSY, iMEM_VALID, iMEM_DATA
  );

  modport slave (
    input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    output iMEM_BUSY, iMEM_VALID, iMEM_DATA
  );

endinterface

// File: rtl/sysreg_spr_addr_calc.sv
// Combinational stack-slot address, updated SPR and alignment check.
// PUSH pre-decrements, POP post-increments; arithmetic wraps modulo 2^N.
module sysreg_spr_addr_calc #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic         pop,
  input  logic [N-1:0] spr,
  output logic [N-1:0] addr,
  output logic [N-1:0] newSpr,
  output logic         misaligned
);

  localparam logic [N-1:0] STEP_N    = N'(STEP);
  localparam logic [N-1:0] STEP_MASK = N'(STEP - 1);

  assign misaligned = |(spr & STEP_MASK);
  assign addr       = pop ? spr : spr - STEP_N;
  assign newSpr     = pop ? spr + STEP_N : spr - STEP_N;

endmodule

// File: rtl/sysreg_spr_stack_ctrl.sv
// Execute-stage PUSH/POP initiator: one memory transaction per command, then
// writes the updated stack pointer back to the SPR register.
module sysreg_spr_stack_ctrl
  import sysreg_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                           iCLOCK,
  input  logic                           inRESET,
  input  logic                           iFLUSH,
  input  logic                           iCMD_VALID,
  input  logic                           iCMD_POP,
  input  logic [N-1:0]                   iCMD_DATA,
  output logic                           oCMD_BUSY,
  input  logic [N-1:0]                   iSPR_DATA,
  sysreg_spr_stack_ctrl_if.master        memBus,
  output logic                           oSPR_REGIST_REQ,
  output logic [N-1:0]                   oSPR_REGIST_DATA,
  output logic                           oPOP_VALID,
  output logic [N-1:0]                   oPOP_DATA,
  output logic                           oFAULT
);

  stackState_t  state, stateNext;
  logic         accept, transfer, finish;
  logic         opPop, memRw, aborted, fault;
  logic [N-1:0] memAddr, memData, newSpr, sprData, popData;
  logic [N-1:0] calcAddr, calcNewSpr;
  logic         calcMisaligned;

  sysreg_spr_addr_calc #(.N(N), .STEP(STEP)) addrCalc (
    .pop        (iCMD_POP),
    .spr        (iSPR_DATA),
    .addr       (calcAddr),
    .newSpr     (calcNewSpr),
    .misaligned (calcMisaligned)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= IDLE;
    // NOTE: registers take <= so every flop samples pre-edge values, whatever the statement order.
    else          state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    stateNext       = state;
    accept          = 1'b0;
    transfer        = 1'b0;
    finish          = 1'b0;
    oCMD_BUSY       = 1'b1;
    memBus.oMEM_REQ = 1'b0;
    oSPR_REGIST_REQ = 1'b0;
    oPOP_VALID      = 1'b0;
    case (state)
      IDLE: begin
        oCMD_BUSY = 1'b0;
        if (iCMD_VALID && !iFLUSH) begin
          accept = 1'b1;
          if (!calcMisaligned) stateNext = REQ;
        end
      end
      REQ: begin
        memBus.oMEM_REQ = 1'b1;
        if (!memBus.iMEM_BUSY) begin
          transfer  = 1'b1;
          stateNext = WAIT;
        end else if (iFLUSH) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        // A flushed transaction still has to drain its response before IDLE.
        if (memBus.iMEM_VALID) begin
          finish    = !(aborted || iFLUSH);
          stateNext = finish ? DONE : IDLE;
        end
      end
      DONE: begin
        oSPR_REGIST_REQ = !iFLUSH;
        oPOP_VALID      = !iFLUSH && opPop;
        stateNext       = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      opPop   <= 1'b0;
      memRw   <= MEM_READ;
      memAddr <= '0;
      memData <= '0;
      newSpr  <= '0;
      aborted <= 1'b0;
      fault   <= 1'b0;
      sprData <= '0;
      popData <= '0;
    end else begin
      fault <= accept && calcMisaligned;
      if (accept && !calcMisaligned) begin
        opPop   <= iCMD_POP;
        memRw   <= iCMD_POP ? MEM_READ : MEM_WRITE;
        memAddr <= calcAddr;
        memData <= iCMD_DATA;
        newSpr  <= calcNewSpr;
        aborted <= 1'b0;
      end
      if ((transfer || state == WAIT) && iFLUSH) aborted <= 1'b1;
      // Result registers update on entry to DONE and then hold.
      if (finish) begin
        sprData <= newSpr;
        if (opPop) popData <= memBus.iMEM_DATA;
      end
    end
  end

  assign memBus.oMEM_RW   = memRw;
  assign memBus.oMEM_ADDR = memAddr;
  assign memBus.oMEM_DATA = memData;
  assign oSPR_REGIST_DATA = sprData;
  assign oPOP_DATA        = popData;
  assign oFAULT           = fault;

endmodule

// File: tb/tb_sysreg_spr_stack_ctrl.sv
// Scoreboard bench for sysreg_spr_stack_ctrl: expected memory transfers, SPR
// writes, POP results and faults are queued at issue and matched by a monitor.
module tb_sysreg_spr_stack_ctrl;

  localparam int N    = 32;
  localparam int STEP = 4;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } memExp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } evtExp_t;

  logic          iCLOCK = 1'b0;
  logic          inRESET = 1'b0;
  logic          iFLUSH = 1'b0;
  logic          iCMD_VALID = 1'b0;
  logic          iCMD_POP = 1'b0;
  logic [N-1:0]  iCMD_DATA = '0;
  logic          oCMD_BUSY;
  logic [N-1:0]  iSPR_DATA;
  logic          oSPR_REGIST_REQ;
  logic [N-1:0]  oSPR_REGIST_DATA;
  logic          oPOP_VALID;
  logic [N-1:0]  oPOP_DATA;
  logic          oFAULT;

  sysreg_spr_stack_ctrl_if #(.N(N)) memBus ();

  sysreg_spr_stack_ctrl #(.N(N), .STEP(STEP)) dut (
    .iCLOCK           (iCLOCK),
    .inRESET          (inRESET),
    .iFLUSH           (iFLUSH),
    .iCMD_VALID       (iCMD_VALID),
    .iCMD_POP         (iCMD_POP),
    .iCMD_DATA        (iCMD_DATA),
    .oCMD_BUSY        (oCMD_BUSY),
    .iSPR_DATA        (iSPR_DATA),
    .memBus           (memBus),
    .oSPR_REGIST_REQ  (oSPR_REGIST_REQ),
    .oSPR_REGIST_DATA (oSPR_REGIST_DATA),
    .oPOP_VALID       (oPOP_VALID),
    .oPOP_DATA        (oPOP_DATA),
    .oFAULT           (oFAULT)
  );

  always #5 iCLOCK = ~iCLOCK;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int reqRun      = 0;

  memExp_t memQ[$];
  evtExp_t sprQ[$];
  evtExp_t popQ[$];
  int      faultQ[$];

  logic [31:0] expSpr = '0;
  logic [31:0] sprReg = '0;
  logic [31:0] sprLoadVal = '0;
  logic        sprLoad = 1'b0;

  assign iSPR_DATA = sprReg;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  // The SPR register the controller writes back to.
  always @(posedge iCLOCK) begin
    if (sprLoad)              sprReg <= sprLoadVal;
    else if (oSPR_REGIST_REQ) sprReg <= oSPR_REGIST_DATA;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic setSpr(input logic [31:0] v);
    sprLoad    = 1'b1;
    sprLoadVal = v;
    tick();
    sprLoad = 1'b0;
    expSpr  = v;
  endtask

  always @(negedge iCLOCK) begin
    if (inRESET) begin
      memExp_t m;
      evtExp_t e;
      if (!memBus.oMEM_REQ) reqRun = 0;
      else                  reqRun++;
      if (memBus.oMEM_REQ && !memBus.iMEM_BUSY) begin
        if (memQ.size() == 0) check("mem_req_unexpected", memBus.oMEM_REQ, 1'b0);
        else begin
          m = memQ.pop_front();
          check("mem_rw", memBus.oMEM_RW, m.rw);
          check("mem_addr", memBus.oMEM_ADDR, m.addr);
          if (m.rw) check("mem_wdata", memBus.oMEM_DATA, m.data);
          check("mem_req_hold", reqRun, m.hold);
        end
      end
      if (oSPR_REGIST_REQ) begin
        if (sprQ.size() == 0) check("spr_req_unexpected", oSPR_REGIST_REQ, 1'b0);
        else begin
          e = sprQ.pop_front();
          check("spr_data", oSPR_REGIST_DATA, e.data);
          check("spr_cycle", cyc, e.cyc);
        end
      end
      if (oPOP_VALID) begin
        if (popQ.size() == 0) check("pop_valid_unexpected", oPOP_VALID, 1'b0);
        else begin
          e = popQ.pop_front();
          check("pop_data", oPOP_DATA, e.data);
          check("pop_cycle", cyc, e.cyc);
        end
      end
      if (oFAULT) begin
        if (faultQ.size() == 0) check("fault_unexpected", oFAULT, 1'b0);
        else check("fault_cycle", cyc, faultQ.pop_front());
      end
    end
  end

  // One complete command: busyN stalled REQ cycles, gapN idle WAIT cycles.
  task automatic doCmd(input logic pop, input logic [31:0] data, input int busyN,
                       input int gapN, input logic [31:0] loadVal);
    logic [31:0] addr, nxt;
    int          acc;
    bit          mis;
    mis  = (expSpr % STEP) != 0;
    addr = pop ? expSpr : expSpr - STEP;
    nxt  = pop ? expSpr + STEP : expSpr - STEP;
    acc  = cyc;
    if (mis) faultQ.push_back(acc + 1);
    else begin
      memQ.push_back('{rw: !pop, addr: addr, data: data, hold: busyN + 1});
      sprQ.push_back('{data: nxt, cyc: acc + 3 + busyN + gapN});
      if (pop) popQ.push_back('{data: loadVal, cyc: acc + 3 + busyN + gapN});
      expSpr = nxt;
    end
    iCMD_VALID       = 1'b1;
    iCMD_POP         = pop;
    iCMD_DATA        = data;
    memBus.iMEM_BUSY = (busyN > 0);
    tick();
    iCMD_VALID = 1'b0;
    if (mis) begin
      check("fault_cmd_busy", oCMD_BUSY, 1'b0);
      check("fault_no_req", memBus.oMEM_REQ, 1'b0);
      tick();
    end else begin
      // A stray response while REQ is stalled must be ignored.
      memBus.iMEM_VALID = (busyN > 0);
      memBus.iMEM_DATA  = 32'hBAD0_BAD0;
      for (int i = 0; i < busyN; i++) tick();
      memBus.iMEM_BUSY  = 1'b0;
      memBus.iMEM_VALID = 1'b0;
      tick();
      for (int i = 0; i < gapN; i++) tick();
      memBus.iMEM_VALID = 1'b1;
      memBus.iMEM_DATA  = loadVal;
      tick();
      memBus.iMEM_VALID = 1'b0;
      tick();
      check("cmd_idle_busy", oCMD_BUSY, 1'b0);
    end
  endtask

  initial begin
    memBus.iMEM_BUSY  = 1'b0;
    memBus.iMEM_VALID = 1'b0;
    memBus.iMEM_DATA  = '0;
    tick();
    tick();
    check("rst_busy", oCMD_BUSY, 1'b0);
    check("rst_mem_req", memBus.oMEM_REQ, 1'b0);
    check("rst_mem_addr", memBus.oMEM_ADDR, 32'h0);
    check("rst_spr_data", oSPR_REGIST_DATA, 32'h0);
    check("rst_pop_data", oPOP_DATA, 32'h0);
    check("rst_fault", oFAULT, 1'b0);
    inRESET = 1'b1;
    tick();

    setSpr(32'h0000_1000);
    doCmd(1'b0, 32'hDEAD_BEEF, 0, 0, 32'h0);
    doCmd(1'b1, 32'h0, 3, 0, 32'h1234_5678);
    check("spr_after_pop", sprReg, expSpr);

    setSpr(32'h0);
    doCmd(1'b0, 32'hCAFE_0001, 0, 1, 32'h0);
    doCmd(1'b1, 32'h0, 1, 2, 32'hA5A5_5A5A);
    check("spr_after_wrap", sprReg, expSpr);

    setSpr(32'h0000_1002);
    doCmd(1'b0, 32'h1111_2222, 0, 0, 32'h0);
    check("misaligned_spr_kept", sprReg, expSpr);

    // Flush while REQ is stalled: the request is withdrawn.
    setSpr(32'h0000_0200);
    iCMD_VALID       = 1'b1;
    iCMD_POP         = 1'b0;
    iCMD_DATA        = 32'h5555_AAAA;
    memBus.iMEM_BUSY = 1'b1;
    tick();
    iCMD_VALID = 1'b0;
    tick();
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    check("flush_req_dropped", memBus.oMEM_REQ, 1'b0);
    check("flush_req_idle", oCMD_BUSY, 1'b0);
    memBus.iMEM_BUSY = 1'b0;
    tick();

    // Flush in WAIT: the response drains, no strobes follow.
    memQ.push_back('{rw: 1'b0, addr: 32'h0000_0200, data: 32'h0, hold: 1});
    iCMD_VALID = 1'b1;
    iCMD_POP   = 1'b1;
    tick();
    iCMD_VALID = 1'b0;
    tick();
    iFLUSH = 1'b1;
    tick();
    iFLUSH            = 1'b0;
    check("flush_wait_busy", oCMD_BUSY, 1'b1);
    memBus.iMEM_VALID = 1'b1;
    memBus.iMEM_DATA  = 32'h7777_8888;
    tick();
    memBus.iMEM_VALID = 1'b0;
    check("flush_wait_idle", oCMD_BUSY, 1'b0);
    tick();
    tick();
    check("flush_spr_kept", sprReg, expSpr);

    // Back-to-back PUSHes using the written-back pointer.
    setSpr(32'h0000_0100);
    doCmd(1'b0, 32'h0000_00A1, 0, 0, 32'h0);
    doCmd(1'b0, 32'h0000_00A2, 0, 0, 32'h0);
    check("b2b_final_spr", sprReg, 32'h0000_00F8);

    // Reset in the middle of WAIT.
    memQ.push_back('{rw: 1'b0, addr: expSpr, data: 32'h0, hold: 1});
    iCMD_VALID = 1'b1;
    iCMD_POP   = 1'b1;
    tick();
    iCMD_VALID = 1'b0;
    tick();
    inRESET = 1'b0;
    #1;
    check("midrst_busy", oCMD_BUSY, 1'b0);
    check("midrst_mem_req", memBus.oMEM_REQ, 1'b0);
    check("midrst_mem_rw", memBus.oMEM_RW, 1'b0);
    check("midrst_mem_addr", memBus.oMEM_ADDR, 32'h0);
    check("midrst_mem_data", memBus.oMEM_DATA, 32'h0);
    check("midrst_spr_req", oSPR_REGIST_REQ, 1'b0);
    check("midrst_spr_data", oSPR_REGIST_DATA, 32'h0);
    check("midrst_pop_valid", oPOP_VALID, 1'b0);
    check("midrst_pop_data", oPOP_DATA, 32'h0);
    check("midrst_fault", oFAULT, 1'b0);
    tick();
    inRESET = 1'b1;
    tick();
    tick();

    check("left_mem", memQ.size(), 0);
    check("left_spr", sprQ.size(), 0);
    check("left_pop", popQ.size(), 0);
    check("left_fault", faultQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sysreg_spr_stack_ctrl.md
Name: sysreg_spr_stack_ctrl

Overview:
- Stack-access initiator in the execute stage. It is the writer/client for the SPR register: reads current SPR via info input, performs PUSH/POP memory transactions, then drives the SPR register's regist request/data with the updated pointer.
- Sits between execute-stage command issue, the load/store memory port and the SPR register.
- One command in flight; fully sequential FSM with memory handshake and abort.

Parameters:
- N, 32, data/address/SPR width.
- STEP, 4, byte step of one stack slot; power of two, ≥1.

Ports:
- iCLOCK  in  1  system clock, rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iFLUSH  in  1  pipeline flush; aborts current command per Behaviour.
- iCMD_VALID  in  1  command request.
- iCMD_POP  in  1  0=PUSH, 1=POP; sampled with iCMD_VALID.
- iCMD_DATA  in  N  PUSH store data.
- oCMD_BUSY  out  1  1 = command not accepted this cycle.
- iSPR_DATA  in  N  current SPR value (SPR info output).
- oMEM_REQ  out  1  memory request.
- oMEM_RW  out  1  0=read (POP), 1=write (PUSH).
- oMEM_ADDR  out  N  byte address.
- oMEM_DATA  out  N  store data.
- iMEM_BUSY  in  1  memory cannot accept; request transfers on oMEM_REQ && !iMEM_BUSY.
- iMEM_VALID  in  1  response (load data or store ack), one cycle.
- iMEM_DATA  in  N  load data.
- oSPR_REGIST_REQ  out  1  SPR write strobe to SPR register.
- oSPR_REGIST_DATA  out  N  new SPR value.
- oPOP_VALID  out  1  POP result valid, one cycle.
- oPOP_DATA  out  N  POP result.
- oFAULT  out  1  misaligned-SPR fault pulse, one cycle.

Behaviour:
- Reset (async, inRESET=0): state IDLE. All outputs 0, including oCMD_BUSY=0. Internal address/data/pointer registers 0.
- States: IDLE, REQ, WAIT, DONE. oCMD_BUSY=1 in REQ/WAIT/DONE.
- Accept: in IDLE with iCMD_VALID && !iFLUSH. Latch op, iCMD_DATA and iSPR_DATA.
  - Misaligned SPR (iSPR_DATA mod STEP ≠ 0): oFAULT=1 next cycle, stay IDLE, no memory access, no SPR write.
- Address/new pointer, modulo 2^N (wrap silently, no fault):
  - PUSH: addr = SPR−STEP; newSPR = SPR−STEP.
  - POP: addr = SPR; newSPR = SPR+STEP.
- REQ (cycle after accept): oMEM_REQ=1 with RW/ADDR/DATA stable. Hold until the cycle with !iMEM_BUSY (transfer), then go to WAIT. oMEM_REQ=0 from the next cycle.
- WAIT: on iMEM_VALID, capture iMEM_DATA and go to DONE. iMEM_VALID outside WAIT is ignored.
- DONE (one cycle):
  - oSPR_REGIST_REQ=1, oSPR_REGIST_DATA=newSPR.
  - POP only: oPOP_VALID=1, oPOP_DATA=loaded data.
  - Next state IDLE.
  - oPOP_DATA and oSPR_REGIST_DATA hold their last values afterwards; strobes are single-cycle.
- Minimum latency, accept to DONE strobe: 3 cycles (accept, REQ transfer, VALID in WAIT at earliest the cycle after transfer, DONE).
- Next accept is possible in the cycle after DONE (IDLE). SPR has already been updated by then, so back-to-back commands see the new pointer.
- iFLUSH:
  - In IDLE: blocks acceptance.
  - In REQ before transfer: drop the request immediately (oMEM_REQ=0 next cycle) and return to IDLE.
  - In REQ during the transfer cycle, or in WAIT: mark aborted. Still wait for iMEM_VALID, then return to IDLE without SPR write or POP_VALID.
  - In DONE: strobes suppressed.
- Mid-operation reset: immediate return to reset values. The memory side is assumed reset by the same signal.

Decomposition:
- Shared package sysreg_pkg: FSM state encoding constants (IDLE/REQ/WAIT/DONE), RW encoding constants (MEM_READ=0, MEM_WRITE=1).
- Optional sub-module sysreg_spr_addr_calc: combinational addr/newSPR/misalign computation from op, SPR, STEP.

Test Plan:
- PUSH, SPR=0x0000_1000, data=0xDEAD_BEEF, iMEM_BUSY=0, ack 1 cycle after transfer -> MEM write addr 0x0FFC data 0xDEADBEEF; SPR_REGIST_REQ pulse with 0x0000_0FFC 3 cycles after accept; no POP_VALID.
- POP, SPR=0x0000_0FFC, iMEM_BUSY high 3 cycles, load 0x1234_5678 -> REQ held 4 cycles at addr 0x0FFC RW=0; POP_VALID with 0x12345678 and SPR write 0x0000_1000 in the same DONE cycle.
- Wrap: PUSH with SPR=0 -> addr/newSPR 0xFFFF_FFFC. POP with SPR=0xFFFF_FFFC -> newSPR 0x0000_0000. No fault in either case.
- Misaligned: SPR=0x0000_1002, PUSH -> oFAULT one cycle, no oMEM_REQ, no SPR write, BUSY stays 0.
- Flush: iFLUSH while REQ stalled by busy -> request dropped, IDLE, no strobes. iFLUSH in WAIT -> response consumed, no SPR write, no POP_VALID.
- Back-to-back PUSH, PUSH with SPR feedback from a real SPR register starting at 0x100 -> addresses 0xFC then 0xF8, final SPR 0xF8. Assert inRESET mid-WAIT -> all outputs 0 immediately.
